// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// One bit per clock: shift-add multiply, restoring divide, sign fix at FIN.
module muldiv_hilo #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         wr_hi,
  input  logic         wr_lo,
  input  logic [n-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo
);

  localparam int CW = $clog2(n) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t         state, next_state;
  logic [CW-1:0]  cnt;
  logic [2*n-1:0] acc;
  logic [n-1:0]   m;
  logic           is_div, dz, sa, sb;

  logic           sgn, a_neg, b_neg;
  logic [n-1:0]   a_mag, b_mag;
  logic [n:0]     sum, sh, trial;
  logic [2*n-1:0] mul_next, div_next, prod;
  logic [n-1:0]   hi_res, lo_res;

  assign busy = (state != IDLE);

  always_comb begin
    sgn   = ~op[0];
    a_neg = sgn & a[n-1];
    b_neg = sgn & b[n-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Divide by zero spends one cycle in CALC without iterating.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (dz || cnt == CW'(1)) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // acc holds {upper, multiplier} for multiply and {rem, quo} for divide.
  always_comb begin
    sum      = {1'b0, acc[2*n-1:n]} + (acc[0] ? {1'b0, m} : '0);
    mul_next = {sum, acc[n-1:1]};
    sh       = {acc[2*n-1:n], acc[n-1]};
    trial    = sh - {1'b0, m};
    div_next = trial[n] ? {sh[n-1:0], acc[n-2:0], 1'b0}
                        : {trial[n-1:0], acc[n-2:0], 1'b1};
  end

  always_comb begin
    prod   = (sa ^ sb) ? -acc : acc;
    hi_res = prod[2*n-1:n];
    lo_res = prod[n-1:0];
    if (dz) begin
      hi_res = sa ? -acc[n-1:0] : acc[n-1:0];
      lo_res = '1;
    end else if (is_div) begin
      lo_res = (sa ^ sb) ? -acc[n-1:0] : acc[n-1:0];
      hi_res = sa ? -acc[2*n-1:n] : acc[2*n-1:n];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      m      <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            dz     <= op[1] && (b == '0);
            sa     <= a_neg;
            sb     <= b_neg;
            cnt    <= CW'(n);
            acc    <= {{n{1'b0}}, (op[1] ? a_mag : b_mag)};
            m      <= op[1] ? b_mag : a_mag;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!dz) acc <= is_div ? div_next : mul_next;
        end
        FIN: begin
          hi   <= hi_res;
          lo   <= lo_res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the CPU datapath.
- Accepts signed or unsigned MULT/DIV commands over a start/busy/done handshake.
- Iterates one bit per clock: shift-add for multiply, restoring for divide.
- Writes the 2n-bit product, or the quotient/remainder, into HI/LO.
- Also services MTHI/MTLO writes. The CPU reads hi/lo directly for MFHI/MFLO.

Parameters:
n, 32, operand/register width (n >= 4)
CW, $clog2(n)+1, iteration-counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  command request; sampled only when busy=0
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  n  operand rs (multiplicand / dividend)
b  input  n  operand rt (multiplier / divisor)
wr_hi  input  1  MTHI strobe
wr_lo  input  1  MTLO strobe
wdata  input  n  data for MTHI/MTLO
busy  output  1  operation in progress
done  output  1  one-cycle pulse: hi/lo hold the new result
hi  output  n  HI register
lo  output  n  LO register

Behaviour:
Reset
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- While reset=1: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, working regs=0.
- Reset asserted mid-operation aborts it. No partial result reaches hi/lo.

State machine: IDLE -> CALC -> FIN -> IDLE
- IDLE, start=1 at edge E0:
  - Latch op and sign flags sa=a[n-1], sb=b[n-1] (signed ops only, else 0).
  - Latch magnitudes |a|, |b|; for signed ops, two's-complement negate when the sign bit is set.
  - Load counter=n, busy->1.
- CALC: one iteration per edge, counter decrements; leave for FIN when counter reaches 0 (edges E1..En).
  - Multiply: 2n-bit accumulator; if multiplier LSB=1 add multiplicand to upper half; then shift right 1 with carry-in.
  - Divide: shift {rem, quo} left 1; trial = rem - |b| as (n+1)-bit subtraction; if non-negative, rem=trial and quo LSB=1.
- FIN at edge En+1: apply sign fix, write hi/lo, busy->0, done->1. Next edge: done->0, state IDLE.
- Latency: done is high during the cycle after En+1, i.e. n+1 edges after the start edge. busy is high for exactly n+1 cycles.

Results
- MULT/MULTU: {hi,lo} = 2n-bit product. Signed: negate the full 2n-bit product when sa^sb.
- DIV/DIVU: lo = quotient, negated when sa^sb. hi = remainder, negated when sa; remainder takes the dividend's sign, quotient truncates toward zero.
- Divide by zero (b=0, either sign mode): skip CALC; FIN at the next edge; hi=a unchanged, lo=all ones; done 2 edges after start.
- Signed overflow (a=-2^(n-1), b=-1): lo=0x8000..0, hi=0. This follows from the magnitude arithmetic with no special case.

Handshake and edge cases
- start while busy=1 is ignored; no queueing.
- start with any op is accepted only in IDLE.
- wr_hi/wr_lo are honoured only when busy=0. When busy=1 they are dropped and hi/lo are unchanged.
- Same-edge wr_hi/wr_lo and start in IDLE: the write takes effect; the command's result overwrites hi/lo at FIN.
- wr_hi and wr_lo together: both registers written with wdata.
- hi/lo hold their value between FIN and the next write. Operands a/b may change after E0.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after start; busy high 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x64, b=0 -> hi=0x64, lo=0xFFFFFFFF, done 2 edges after start.
- DIVU a=100, b=7 started; re-pulse start with MULTU and toggle wr_hi (wdata=0xDEAD) while busy -> both ignored; final hi=2, lo=14.
- MTHI wdata=0x12345678 and MTLO wdata=0x9ABCDEF0 in IDLE -> hi/lo take those values next edge; done stays 0.
- Start MULTU 5*6; assert reset at edge E10 -> hi=lo=0, busy=done=0 immediately. After release, a new MULTU 5*6 -> lo=0x1E, hi=0 after 33 edges.
